// File: rtl/cpu_types_pkg.sv
// Shared CPU types: ALU selects, EXU requester FSM states and
// functional-unit timeout constants.
package cpu_types_pkg;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_SLT,
        ALU_SLTU
    } alusel_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } exu_req_state_e;

    localparam int FU_TIMEOUT_DEFAULT = 64;
    localparam logic [31:0] FU_TIMEOUT_PATTERN = 32'hdeadbeef;

endpackage

// File: rtl/exu_fu_requester_if.sv
// Bundle of upstream, functional-unit and downstream handshake signals.
// master = the EXU requester, slave = its environment.
interface exu_fu_requester_if #(
    parameter int WIDTH = 32
);
    import cpu_types_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    alusel_e          in_op;
    logic [4:0]       in_rd;

    logic             fu_valid;
    logic [WIDTH-1:0] fu_a;
    logic [WIDTH-1:0] fu_b;
    alusel_e          fu_op;
    logic             fu_ready;
    logic [WIDTH-1:0] fu_result;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [4:0]       out_rd;

    logic             busy;
    logic             timeout_err;

    modport master (
        input  in_valid, in_a, in_b, in_op, in_rd,
        input  fu_ready, fu_result, out_ready,
        output in_ready, fu_valid, fu_a, fu_b, fu_op,
        output out_valid, out_result, out_rd,
        output busy, timeout_err
    );

    modport slave (
        output in_valid, in_a, in_b, in_op, in_rd,
        output fu_ready, fu_result, out_ready,
        input  in_ready, fu_valid, fu_a, fu_b, fu_op,
        input  out_valid, out_result, out_rd,
        input  busy, timeout_err
    );

endinterface

// File: rtl/fu_watchdog.sv
// WAIT-cycle counter with expiry compare; only built when
// EXU_FU_TIMEOUT_EN is defined.
`ifdef EXU_FU_TIMEOUT_EN
module fu_watchdog #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear)
            cnt_d = '0;
        else if (run && cnt_q != CW'(LIMIT))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    // fires on the LIMIT-th WAIT cycle so DONE follows exactly LIMIT cycles
    assign expired = run && (cnt_q == CW'(LIMIT - 1));

endmodule
`endif

// File: rtl/exu_fu_requester.sv
// EXU-side initiator for the single-pulse FU handshake.
// Optional watchdog: define EXU_FU_TIMEOUT_EN.
module exu_fu_requester
    import cpu_types_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = FU_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    exu_fu_requester_if.master bus
);

    exu_req_state_e   state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    alusel_e          op_q, op_d;
    logic [4:0]       rd_q, rd_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             in_ready;

`ifdef EXU_FU_TIMEOUT_EN
    logic err_q, err_d;
    logic expired;

    fu_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_q == S_ISSUE),
        .run     (state_q == S_WAIT),
        .expired (expired)
    );
`endif

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        rd_d     = rd_q;
        res_d    = res_q;
`ifdef EXU_FU_TIMEOUT_EN
        err_d    = err_q;
`endif
        in_ready = (state_q == S_IDLE) ||
                   (state_q == S_DONE && bus.out_ready);

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (in_ready) begin
                    state_d = bus.in_valid ? S_ISSUE : S_IDLE;
                    if (bus.in_valid) begin
                        a_d  = bus.in_a;
                        b_d  = bus.in_b;
                        op_d = bus.in_op;
                        rd_d = bus.in_rd;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.fu_ready) begin
                    res_d   = bus.fu_result;
                    state_d = S_DONE;
                end
`ifdef EXU_FU_TIMEOUT_EN
                else if (expired) begin
                    res_d   = WIDTH'(FU_TIMEOUT_PATTERN);
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= ALU_ADD;
            rd_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            res_q   <= res_d;
        end
    end

`ifdef EXU_FU_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_q <= 1'b0;
        else
            err_q <= err_d;
    end

    assign bus.timeout_err = err_q;
`else
    assign bus.timeout_err = 1'b0;
`endif

    assign bus.in_ready   = in_ready;
    assign bus.fu_valid   = (state_q == S_ISSUE);
    assign bus.fu_a       = a_q;
    assign bus.fu_b       = b_q;
    assign bus.fu_op      = op_q;
    assign bus.out_valid  = (state_q == S_DONE);
    assign bus.out_result = res_q;
    assign bus.out_rd     = rd_q;
    assign bus.busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_exu_fu_requester.sv
// Bench for exu_fu_requester: table vectors, random ops against an
// ALU reference, and hand sequences for back-to-back, reset, timeout.
module tb_exu_fu_requester;
    import cpu_types_pkg::*;

    localparam int W = 32;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    exu_fu_requester_if #(.WIDTH(W)) bus ();

    exu_fu_requester #(
        .WIDTH          (W),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int          sl_cnt   = 0;
    int          sl_delay = 1;
    logic [31:0] sl_res   = '0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        alusel_e     op;
        logic [4:0]  rd;
        int          dly;
        int          hold;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[10];

    function automatic logic [31:0] alu(
        input logic [31:0] a, input logic [31:0] b, input alusel_e op);
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_SLL:  return a << b[4:0];
            ALU_SRL:  return a >> b[4:0];
            ALU_SRA:  return $unsigned($signed(a) >>> b[4:0]);
            ALU_SLT:  return {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU: return {31'd0, a < b};
            default:  return 32'd0;
        endcase
    endfunction

    function automatic void check(
        input string name, input logic [95:0] got, input logic [95:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endfunction

    // one clock; the slave answers sl_delay cycles after each fu_valid
    task automatic step();
        @(posedge clk);
        #1;
        bus.fu_ready = 1'b0;
        if (sl_cnt > 0) begin
            sl_cnt--;
            if (sl_cnt == 0) begin
                bus.fu_ready  = 1'b1;
                bus.fu_result = sl_res;
            end
        end
        if (bus.fu_valid && sl_delay > 0) begin
            sl_cnt = sl_delay;
            sl_res = alu(bus.fu_a, bus.fu_b, bus.fu_op);
        end
    endtask

    task automatic accept(
        input logic [31:0] a, input logic [31:0] b, input alusel_e op,
        input logic [4:0] rd, input int dly);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_op    = op;
        bus.in_rd    = rd;
        sl_delay     = dly;
        #1;
        check("in_ready_accept", bus.in_ready, 1'b1);
        step();
        bus.in_valid = 1'b0;
        bus.in_a     = $urandom;
        bus.in_b     = $urandom;
        check("issue", {bus.fu_valid, bus.out_valid, bus.fu_a, bus.fu_b, bus.fu_op},
              {1'b1, 1'b0, a, b, op});
    endtask

    task automatic wait_done(
        input logic [31:0] a, input logic [31:0] b, input alusel_e op,
        input logic [4:0] rd, input int lat, input logic [31:0] exp,
        input logic err);
        int n;
        n = 0;
        do begin
            step();
            n++;
            if (!bus.out_valid)
                check("fu_hold", {bus.fu_valid, bus.in_ready, bus.fu_a, bus.fu_b, bus.fu_op},
                      {1'b0, 1'b0, a, b, op});
        end while (!bus.out_valid && n < 40);
        check("latency", n, lat + 1);
        check("result", {bus.out_valid, bus.out_result, bus.out_rd},
              {1'b1, exp, rd});
        check("timeout_err", bus.timeout_err, err);
    endtask

    task automatic release_out(
        input int hold, input logic [31:0] exp, input logic [4:0] rd);
        for (int i = 0; i < hold; i++) begin
            step();
            check("backpressure", {bus.out_valid, bus.in_ready, bus.out_result, bus.out_rd},
                  {1'b1, 1'b0, exp, rd});
        end
        bus.out_ready = 1'b1;
        #1;
        check("in_ready_release", bus.in_ready, 1'b1);
        step();
        bus.out_ready = 1'b0;
        check("drain", {bus.out_valid, bus.busy, bus.in_ready}, {1'b0, 1'b0, 1'b1});
    endtask

    initial begin
        logic [31:0] ra, rb, rexp;
        logic [4:0]  rrd;
        alusel_e     rop;
        int          rdly, rhold;

        tbl[0] = '{32'd5, 32'd3, ALU_ADD, 5'd7, 1, 0, 32'd8};
        tbl[1] = '{32'd5, 32'd3, ALU_ADD, 5'd7, 1, 4, 32'd8};
        tbl[2] = '{32'd10, 32'd4, ALU_SUB, 5'd9, 1, 0, 32'd6};
        tbl[3] = '{32'd0, 32'd1, ALU_SUB, 5'd1, 2, 0, 32'hffffffff};
        tbl[4] = '{32'hf0f0, 32'hff00, ALU_AND, 5'd3, 3, 1, 32'h0000f000};
        tbl[5] = '{32'h1234, 32'd4, ALU_SLL, 5'd31, 1, 0, 32'h00012340};
        tbl[6] = '{32'h80000000, 32'd4, ALU_SRA, 5'd2, 4, 0, 32'hf8000000};
        tbl[7] = '{32'hffffffff, 32'd1, ALU_SLT, 5'd0, 5, 2, 32'd1};
        tbl[8] = '{32'hffffffff, 32'd1, ALU_SLTU, 5'd4, 1, 0, 32'd0};
        tbl[9] = '{32'h00ff00ff, 32'h0f0f0f0f, ALU_XOR, 5'd12, 6, 0, 32'h0ff00ff0};

        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_op     = ALU_ADD;
        bus.in_rd     = '0;
        bus.fu_ready  = 1'b0;
        bus.fu_result = '0;
        bus.out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_state",
              {bus.in_ready, bus.fu_valid, bus.out_valid, bus.busy, bus.timeout_err},
              {1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        check("reset_regs", {bus.fu_a, bus.fu_b, bus.out_result, bus.out_rd},
              {32'd0, 32'd0, 32'd0, 5'd0});
        rst = 1'b0;
        step();

        for (int i = 0; i < 10; i++) begin
            accept(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].rd, tbl[i].dly);
            wait_done(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].rd,
                      tbl[i].dly, tbl[i].exp, 1'b0);
            release_out(tbl[i].hold, tbl[i].exp, tbl[i].rd);
        end

        for (int i = 0; i < 40; i++) begin
            ra    = $urandom;
            rb    = (i % 3 == 0) ? 32'($urandom_range(0, 31)) : $urandom;
            rop   = alusel_e'($urandom_range(0, 9));
            rrd   = 5'($urandom_range(0, 31));
            rdly  = $urandom_range(1, TMO - 1);
            rhold = $urandom_range(0, 3);
            rexp  = alu(ra, rb, rop);
            accept(ra, rb, rop, rrd, rdly);
            wait_done(ra, rb, rop, rrd, rdly, rexp, 1'b0);
            release_out(rhold, rexp, rrd);
        end

        // back-to-back: second op accepted in the DONE cycle
        accept(32'd20, 32'd22, ALU_ADD, 5'd5, 1);
        wait_done(32'd20, 32'd22, ALU_ADD, 5'd5, 1, 32'd42, 1'b0);
        bus.out_ready = 1'b1;
        accept(32'd10, 32'd4, ALU_SUB, 5'd6, 1);
        bus.out_ready = 1'b0;
        wait_done(32'd10, 32'd4, ALU_SUB, 5'd6, 1, 32'd6, 1'b0);
        release_out(0, 32'd6, 5'd6);

        // spurious fu_ready in IDLE and in ISSUE, slow slave
        bus.fu_ready  = 1'b1;
        bus.fu_result = 32'hbad0bad0;
        step();
        check("idle_spurious", {bus.busy, bus.out_valid, bus.in_ready},
              {1'b0, 1'b0, 1'b1});
        accept(32'd100, 32'd7, ALU_OR, 5'd11, 5);
        bus.fu_ready  = 1'b1;
        bus.fu_result = 32'hbad1bad1;
        wait_done(32'd100, 32'd7, ALU_OR, 5'd11, 5, 32'd103, 1'b0);
        release_out(1, 32'd103, 5'd11);

`ifdef EXU_FU_TIMEOUT_EN
        accept(32'd9, 32'd9, ALU_ADD, 5'd1, TMO);
        wait_done(32'd9, 32'd9, ALU_ADD, 5'd1, TMO, 32'd18, 1'b0);
        release_out(0, 32'd18, 5'd1);
        accept(32'd1, 32'd2, ALU_ADD, 5'd2, 0);
        wait_done(32'd1, 32'd2, ALU_ADD, 5'd2, TMO, 32'hdeadbeef, 1'b1);
        release_out(0, 32'hdeadbeef, 5'd2);
        accept(32'd3, 32'd4, ALU_ADD, 5'd3, 2);
        wait_done(32'd3, 32'd4, ALU_ADD, 5'd3, 2, 32'd7, 1'b1);
        release_out(0, 32'd7, 5'd3);
        check("err_sticky", bus.timeout_err, 1'b1);
`endif

        // asynchronous reset while waiting on the unit
        accept(32'd50, 32'd60, ALU_ADD, 5'd8, 0);
        step();
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", {bus.busy, bus.in_ready, bus.fu_valid, bus.out_valid},
              {1'b0, 1'b1, 1'b0, 1'b0});
        sl_cnt = 0;
        step();
        rst = 1'b0;
        step();
        bus.fu_ready  = 1'b1;
        bus.fu_result = 32'd110;
        step();
        check("stale_ready", {bus.out_valid, bus.busy, bus.in_ready, bus.timeout_err},
              {1'b0, 1'b0, 1'b1, 1'b0});
        step();
        check("post_rst_idle", {bus.out_valid, bus.busy, bus.fu_valid},
              {1'b0, 1'b0, 1'b0});

        sl_delay = 1;
        accept(32'd2, 32'd3, ALU_ADD, 5'd9, 1);
        wait_done(32'd2, 32'd3, ALU_ADD, 5'd9, 1, 32'd5, 1'b0);
        release_out(0, 32'd5, 5'd9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/exu_fu_requester.md
Name: exu_fu_requester

Overview:
- EXU-side initiator for the single-pulse valid/ready functional-unit handshake.
- Accepts one decoded operation from upstream (IDU side) with a valid/ready handshake.
- Issues the operation to a slave functional unit (ALU or a later multi-cycle unit) and captures the result when the unit pulses ready.
- Presents the result to downstream (WBU side) with a valid/ready handshake.

Parameters:
WIDTH, 32, datapath width of operands and result
TIMEOUT_CYCLES, 64, watchdog limit in WAIT cycles (used only with EXU_FU_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  upstream operation valid
in_ready  out  1  block can accept an operation this cycle
in_a  in  WIDTH  operand A
in_b  in  WIDTH  operand B
in_op  in  alusel_e  operation select
in_rd  in  5  destination register index
fu_valid  out  1  one-cycle issue pulse to the functional unit
fu_a  out  WIDTH  latched operand A, stable from issue through ready
fu_b  out  WIDTH  latched operand B, stable from issue through ready
fu_op  out  alusel_e  latched operation, stable from issue through ready
fu_ready  in  1  unit result-valid pulse
fu_result  in  WIDTH  unit result, sampled only when fu_ready=1 in WAIT
out_valid  out  1  result available downstream
out_ready  in  1  downstream accepts result
out_result  out  WIDTH  captured result
out_rd  out  5  captured destination index
busy  out  1  state != S_IDLE
timeout_err  out  1  sticky watchdog error flag (0 when feature disabled)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high; it forces S_IDLE immediately.
- Reset values: all outputs 0 and all internal registers 0, except in_ready, which is 1 once in S_IDLE.
- FSM states are S_IDLE, S_ISSUE, S_WAIT, S_DONE. The state register is the only path to outputs; all outputs are Moore except in_ready.
- S_IDLE:
  - in_ready=1.
  - On in_valid, latch in_a, in_b, in_op, in_rd and go to S_ISSUE.
- S_ISSUE:
  - fu_valid=1 for exactly this cycle; then go to S_WAIT unconditionally.
  - fu_ready in this cycle is ignored.
  - fu_valid is never held high for more than one cycle. This prevents the slave from re-entering its compute state.
- S_WAIT:
  - fu_valid=0.
  - On fu_ready=1, capture fu_result into out_result and go to S_DONE.
  - Otherwise stay.
- S_DONE:
  - out_valid=1; out_result and out_rd are stable.
  - On out_ready, out_valid drops next cycle.
  - Back-to-back: in_ready = (state==S_IDLE) || (state==S_DONE && out_ready). If in_valid is also 1, latch the new operation and go straight to S_ISSUE; otherwise go to S_IDLE.
- fu_ready outside S_WAIT is ignored in every state. A stale pulse after a mid-operation reset therefore has no effect.
- Latency with a 1-cycle slave:
  - Accept in cycle T.
  - fu_valid at T+1.
  - fu_ready at T+2.
  - out_valid at T+3.
  - Sustained throughput is one operation per 3 cycles with out_ready held at 1.
- Operand registers change only on acceptance.
- fu_a, fu_b and fu_op hold their last values in S_IDLE and are not cleared between operations.
- Reset mid-operation: all in-flight state is discarded. No out_valid is produced for the aborted operation.

Optional Feature:
- Macro: EXU_FU_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to S_WAIT and increments each cycle in S_WAIT.
  - When it reaches TIMEOUT_CYCLES without fu_ready, capture 32'hdeadbeef (zero-extended or truncated to WIDTH), set timeout_err, and go to S_DONE.
  - timeout_err clears only on rst.
  - If fu_ready and expiry coincide, fu_ready wins and no error is raised.
- Not defined: S_WAIT waits indefinitely, timeout_err is tied to 0, and no counter logic exists.

Decomposition:
- cpu_types_pkg holds the existing alusel_e, plus new exu_req_state_e (S_IDLE, S_ISSUE, S_WAIT, S_DONE) and constant FU_TIMEOUT_DEFAULT=64.
- One sub-module, fu_watchdog (counter plus expiry compare), instantiated only under EXU_FU_TIMEOUT_EN.

Test Plan:
1. Reset then single op: A=5, B=3, op=ALU_ADD, rd=7, slave ready one cycle after valid -> fu_valid one pulse at T+1; out_valid at T+3 with out_result=8, out_rd=7.
2. Backpressure: out_ready=0 for 4 cycles after out_valid -> out_valid, out_result and out_rd hold; in_ready=0 throughout; release -> in_ready=1 same cycle.
3. Back-to-back: second op (SUB 10,4) presented with in_valid while S_DONE and out_ready=1 -> accepted that cycle; fu_valid next cycle; result 6.
4. Slow slave with fu_ready delayed 5 cycles; spurious fu_ready pulse in S_ISSUE and in S_IDLE -> ignored; fu_valid stays a single pulse; fu_a, fu_b, fu_op stable until ready.
5. Async rst asserted in S_WAIT, then fu_ready pulse after reset release -> state S_IDLE, out_valid never asserted, in_ready=1.
6. With EXU_FU_TIMEOUT_EN and TIMEOUT_CYCLES=8, slave never ready -> after 8 WAIT cycles out_result=32'hdeadbeef and timeout_err=1 (sticky); repeat with fu_ready on the expiry cycle -> real result and timeout_err unchanged.
